// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro: FETCH_ALIGN_CHECK_EN enables the redirect-alignment
// and instruction-memory range fault check.
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Fetch stage sequencing states
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    // Sequential next address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch stage: redirect, sequential advance or hold,
// plus the optional alignment / range fault detection.
// Optional build macro: FETCH_ALIGN_CHECK_EN (fault checks; otherwise redirect
// targets are silently word-aligned and no fault is ever raised).
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  fetch_state_t state,
    input  logic [31:0]  pc,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         id_valid,
    input  logic         id_ready,
    output logic [31:0]  pc_next,
    output logic [31:0]  pc_plus4,
    output logic         advance,
    output logic         align_fault,
    output logic         range_fault
);

    localparam logic [29:0] DEPTH_LIM = 30'(IMEM_DEPTH);

    logic        accept;
    logic [31:0] redirect_target;

    // Output slot can take a new word when empty or being consumed.
    assign accept   = !id_valid || id_ready;
    assign pc_plus4 = pc_incr(pc);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
    assign align_fault     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign range_fault     = (state == S_RUN) && (pc[31:2] >= DEPTH_LIM);
`else
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign align_fault     = 1'b0;
    assign range_fault     = 1'b0;
    logic unused_cfg;
    assign unused_cfg = &{1'b0, redirect_pc[1:0], DEPTH_LIM};
`endif

    // A new word is captured from RUN when the slot accepts, or leaving HOLD.
    always_comb begin
        advance = ((state == S_RUN) && accept) || ((state == S_HOLD) && id_ready);
    end

    // Priority: fault freeze, redirect, range fault, sequential advance, hold.
    always_comb begin
        pc_next = pc;
        if (state == S_FAULT) begin
            pc_next = pc;
        end else if (redirect_valid) begin
            pc_next = align_fault ? pc : redirect_target;
        end else if (range_fault) begin
            pc_next = pc;
        end else if ((state != S_BOOT) && advance) begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory and registers instruction + PC into a valid/ready slot
// for decode. Redirects re-steer the PC and flush the slot.
// Handshake: id_* transfers on a rising edge where id_valid && id_ready;
// id_* hold steady while id_valid && !id_ready.
// Optional build macro: FETCH_ALIGN_CHECK_EN (sticky fetch_fault on misaligned
// redirect or out-of-range PC; fetch_fault stays 0 otherwise).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic               fetch_fault,
    output fetch_state_t       dbg_state
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         advance;
    logic         align_fault;
    logic         range_fault;

    fetch_pc_gen #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_gen (
        .state          (state),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .pc_next        (pc_next),
        .pc_plus4       (pc_plus4),
        .advance        (advance),
        .align_fault    (align_fault),
        .range_fault    (range_fault)
    );

    assign imem_addr = pc;
    assign dbg_state = state;

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Fetch sequencing FSM and the registered decode slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_BOOT;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    if (redirect_valid) begin
                        // Any word in the slot is flushed; a handshake this
                        // edge still completes on the decode side.
                        id_valid <= 1'b0;
                        if (align_fault) begin
                            fetch_fault <= 1'b1;
                            state       <= S_FAULT;
                        end else begin
                            state <= S_RUN;
                        end
                    end else if (range_fault) begin
                        fetch_fault <= 1'b1;
                        id_valid    <= 1'b0;
                        state       <= S_FAULT;
                    end else if (state == S_BOOT) begin
                        state <= S_RUN;
                    end else if (advance) begin
                        id_valid    <= 1'b1;
                        id_instr    <= imem_rdata;
                        id_pc       <= pc;
                        id_pc_plus4 <= pc_plus4;
                        state       <= S_RUN;
                    end else begin
                        state <= S_HOLD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the main scenarios followed by
// randomized redirect / backpressure / reset traffic against a stream model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_DEPTH = 1024;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         id_ready;
    logic         id_valid;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc;
    logic [31:0]  id_pc_plus4;
    logic         fetch_fault;
    fetch_state_t dbg_state;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault),
        .dbg_state      (dbg_state)
    );

    // instruction memory (combinational); addresses beyond the array return a
    // pattern derived from the address so every fetch is distinguishable
    logic [31:0] mem [0:1023];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr[31:12] == 20'h0) return mem[addr[11:2]];
        return {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // scoreboard counters
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: the slot seen by decode and the next fetch address
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_valid, m_boot, m_hold, m_fault, m_known;

    task automatic model_edge(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        if (!r) begin
            m_pc = RESET_PC; m_boot = 1'b1; m_hold = 1'b0; m_fault = 1'b0;
            m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_ip4 = '0; m_known = 1'b1;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (rv) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1; m_valid = 1'b0;
            end else begin
                m_pc = rpc; m_valid = 1'b0; m_boot = 1'b0; m_hold = 1'b0;
            end
`else
            m_pc = rpc & 32'hFFFF_FFFC; m_valid = 1'b0; m_boot = 1'b0; m_hold = 1'b0;
`endif
        end else if (m_boot) begin
            m_boot = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        end else if (!m_hold && ((m_pc / 4) >= IMEM_DEPTH)) begin
            m_fault = 1'b1; m_valid = 1'b0;
`endif
        end else if (!m_valid || rdy) begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4; m_hold = 1'b0;
        end else begin
            m_hold = 1'b1;
        end
    endtask

    function automatic fetch_state_t exp_state();
        if (m_fault) return S_FAULT;
        if (m_boot)  return S_BOOT;
        if (m_hold)  return S_HOLD;
        return S_RUN;
    endfunction

    // driver: one clock of stimulus, model update and full output comparison
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        #1;
        if (m_known) check("imem_addr_pre", imem_addr, m_pc);
        @(posedge clk);
        model_edge(r, rv, rpc, rdy);
        #1;
        check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check("id_instr", id_instr, m_instr);
        check("id_pc", id_pc, m_ipc);
        check("id_pc_plus4", id_pc_plus4, m_ip4);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        check("state", {30'b0, dbg_state}, {30'b0, exp_state()});
        check("imem_addr", imem_addr, m_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, rv, rdy;
        logic [31:0] rpc;
        m_known = 1'b0;
        m_pc = '0; m_instr = '0; m_ipc = '0; m_ip4 = '0;
        m_valid = 1'b0; m_boot = 1'b1; m_hold = 1'b0; m_fault = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        mem[0] = 32'h0062E233;
        mem[1] = 32'h00832383;
        mem[2] = 32'h0064A423;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

        // reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_state_boot", {30'b0, dbg_state}, {30'b0, S_BOOT});
        check("rst_addr", imem_addr, RESET_PC);

        // boot bubble then back-to-back fetch
        step(1, 0, 0, 1);
        check("boot_bubble", {31'b0, id_valid}, 32'd0);
        step(1, 0, 0, 1);
        check("first_valid", {31'b0, id_valid}, 32'd1);
        check("first_instr", id_instr, 32'h0062E233);
        step(1, 0, 0, 1);
        check("second_pc", id_pc, 32'h4);
        check("second_instr", id_instr, 32'h00832383);

        // backpressure for 3 cycles at id_pc=4
        repeat (3) step(1, 0, 0, 0);
        check("hold_pc", id_pc, 32'h4);
        check("hold_addr", imem_addr, 32'h8);
        check("hold_state", {30'b0, dbg_state}, {30'b0, S_HOLD});
        step(1, 0, 0, 1);
        check("release_pc", id_pc, 32'h8);
        check("release_instr", id_instr, 32'h0064A423);

        // redirect while holding a valid word
        step(1, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        check("redir_flush", {31'b0, id_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        step(1, 0, 0, 1);
        check("redir_target_pc", id_pc, 32'h40);

        // PC wrap at top of address space
        step(1, 1, 32'hFFFF_FFFC, 1);
        step(1, 0, 0, 1);
`ifndef FETCH_ALIGN_CHECK_EN
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'h0);
`endif
        step(1, 0, 0, 1);
`ifndef FETCH_ALIGN_CHECK_EN
        check("wrap_next_pc", id_pc, 32'h0);
`endif

        // reset asserted in HOLD together with a redirect
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("pre_rst_hold", {30'b0, dbg_state}, {30'b0, S_HOLD});
        step(0, 1, 32'h80, 0);
        check("rst_over_redir_state", {30'b0, dbg_state}, {30'b0, S_BOOT});
        check("rst_over_redir_valid", {31'b0, id_valid}, 32'd0);
        check("rst_over_redir_addr", imem_addr, RESET_PC);

        // misaligned redirect
        step(1, 0, 0, 1);
        step(1, 1, 32'h0000_0006, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_fault", {31'b0, fetch_fault}, 32'd1);
        check("align_fault_valid", {31'b0, id_valid}, 32'd0);
        step(1, 1, 32'h20, 1);
        check("fault_ignores_redir", {30'b0, dbg_state}, {30'b0, S_FAULT});
`else
        check("misalign_forced", imem_addr, 32'h4);
        check("misalign_no_fault", {31'b0, fetch_fault}, 32'd0);
`endif
        step(0, 0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 49) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = 32'($urandom_range(0, 1100)) << 2;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF4;
            step(r, rv, rpc, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction with its PC into a valid/ready hand-off to decode. Redirects from branch/jump resolution re-steer the PC and flush the registered instruction.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded while reset is asserted.
- IMEM_DEPTH, 1024: instruction memory depth in words; used only by the fault check.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_addr  out  32  byte address to instruction memory; equals pc register.
- imem_rdata  in  32  instruction word from memory, combinational from imem_addr.
- redirect_valid  in  1  take redirect_pc as next PC this edge.
- redirect_pc  in  32  redirect target byte address.
- id_ready  in  1  decode accepts id_* this cycle.
- id_valid  out  1  id_instr/id_pc/id_pc_plus4 hold a live instruction.
- id_instr  out  32  registered instruction.
- id_pc  out  32  address of id_instr.
- id_pc_plus4  out  32  id_pc + 4, mod 2^32.
- fetch_fault  out  1  sticky fault flag (0 when check compiled out).

## Operation
- Reset (rst=0 at edge): pc=RESET_PC, state=S_BOOT, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, fetch_fault=0.
- accept = !id_valid | id_ready.
- S_BOOT: one bubble cycle after reset release; no capture; next state S_RUN.
- S_RUN: if accept, capture imem_rdata, pc, pc+4 into id_*, id_valid=1, pc<=pc+4; if !accept, hold pc and id_*, go S_HOLD.
- S_HOLD: pc and id_* frozen; imem_addr stays at the next PC. When id_ready=1: capture as in S_RUN, return to S_RUN.
- Redirect (highest priority, any state except S_FAULT): pc<=redirect_pc, id_valid<=0, state<=S_RUN; the word fetched this cycle is discarded, id_ready ignored.
- Redirect while id_valid=1 and id_ready=1: handshake completes (decode consumes id_*), then flush applies.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; no flag.
- id_* change only on capture or reset; id_valid clears only on redirect/consume-without-capture (never occurs in S_RUN/S_HOLD since capture follows accept).
- Reset mid-operation overrides all: values above next edge regardless of state or redirect.

## Timing
- imem_addr = pc, combinational from register, zero latency.
- Fetch latency: instruction at pc=X valid on id_* the edge after X is presented with accept=1.
- First instruction after reset release: id_valid=1 two edges after first rst=1 edge (BOOT bubble + capture).
- Redirect at edge n: imem_addr=target after n; target instruction on id_* after n+1; throughput one instruction/cycle when id_ready stays 1.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0, or pc[31:2]>=IMEM_DEPTH in S_RUN, sets fetch_fault=1, id_valid=0, state=S_FAULT; S_FAULT holds all outputs and ignores redirects until reset.
- Undefined: redirect_pc[1:0] forced to 2'b00 on load, no range check, fetch_fault tied 0, S_FAULT unreachable.

## Structure
- Package fetch_pkg: state enum (S_BOOT, S_RUN, S_HOLD, S_FAULT), RESET_PC default, instruction width 32, PC increment 4.
- One sub-module fetch_pc_gen: combinational next-PC selection (reset/redirect/+4/hold) plus alignment/range check; state machine and id_* registers stay in fetch_unit.

## Test plan
- Reset release, id_ready=1, memory words 0..2 = 32'h0062E233, 32'h00832383, 32'h0064A423 -> id_valid rises 2 edges after release; id_pc 0,4,8 with those instructions on consecutive cycles.
- id_ready=0 for 3 cycles at id_pc=4 -> id_* frozen, imem_addr=8 held, state S_HOLD; id_ready=1 -> id_pc=8 next edge, no instruction lost or duplicated.
- redirect_valid=1, redirect_pc=32'h40 while id_valid=1, id_ready=0 -> id_valid=0 next edge, imem_addr=32'h40, id_pc=32'h40 the edge after.
- pc forced via redirect to 32'hFFFF_FFFC (check disabled) -> id_pc_plus4=0, next id_pc=0.
- rst=0 asserted in S_HOLD with redirect_valid=1 -> next edge pc=RESET_PC, id_valid=0, state S_BOOT.
- FETCH_ALIGN_CHECK_EN: redirect_pc=32'h0000_0006 -> fetch_fault=1, id_valid=0, later redirects ignored until reset; without macro imem_addr=32'h4.
